// File: rtl/main_control_unit_if.sv
// Host/worker bus of main_control_unit: job start/config, dispatch handshake, completion and status.
// MAIN_CU_PERF_EN adds the o_Cycle_Count output.
interface main_control_unit_if #(
   parameter int NUM_CU      = 2,
   parameter int index_width = 8,
   parameter int max_mu_log  = 8
);
   logic                   i_Start;
   logic [31:0]            i_Config;
   logic [max_mu_log-1:0]  o_mu;
   logic [index_width-1:0] o_Row_Index;
   logic [index_width-1:0] o_Column_Index;
   logic [NUM_CU-1:0]      o_Indexes_Ready;
   logic [NUM_CU-1:0]      i_Indexes_Received;
   logic [NUM_CU-1:0]      i_Result_Ready;
   logic                   o_Busy;
   logic                   o_Done;
   logic                   o_Error;
`ifdef MAIN_CU_PERF_EN
   logic [31:0]            o_Cycle_Count;
`endif

   modport slave (
      input  i_Start, i_Config, i_Indexes_Received, i_Result_Ready,
      output o_mu, o_Row_Index, o_Column_Index, o_Indexes_Ready, o_Busy, o_Done, o_Error
`ifdef MAIN_CU_PERF_EN
      , output o_Cycle_Count
`endif
   );

   modport master (
      output i_Start, i_Config, i_Indexes_Received, i_Result_Ready,
      input  o_mu, o_Row_Index, o_Column_Index, o_Indexes_Ready, o_Busy, o_Done, o_Error
`ifdef MAIN_CU_PERF_EN
      , input o_Cycle_Count
`endif
   );
endinterface

// File: rtl/main_control_unit.sv
// Dispatches the N*P blocks C_ij in row-major order to the lowest free worker and tracks completions.
// MAIN_CU_PERF_EN adds a saturating busy-cycle counter on o_Cycle_Count.
module main_control_unit #(
   parameter int NUM_CU      = 2,
   parameter int index_width = 8,
   parameter int max_mu_log  = 8
) (
   input  logic               i_Clock,
   input  logic               i_Reset,
   main_control_unit_if.slave bus
);
   localparam int CW = 2 * index_width;

   typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_ACK, DRAIN, FINISH} state_t;

   state_t                 state_q, state_d;
   logic [index_width-1:0] p_q, p_d, row_q, row_d, col_q, col_d;
   logic [max_mu_log-1:0]  mu_q, mu_d;
   logic [CW-1:0]          total_q, total_d, issued_q, issued_d, completed_q, completed_d;
   logic [NUM_CU-1:0]      busy_q, busy_d, ready_q, ready_d;
   logic                   error_q, error_d, done_q;

   logic [NUM_CU-1:0]      free, pick, good_res, bad_res;
   logic [CW-1:0]          good_cnt;
   logic [index_width-1:0] cfg_n, cfg_p;
   logic                   ack, busy_o, cfg_unused;

   assign cfg_unused = ^bus.i_Config[31:24];

   always_comb begin
      cfg_n    = index_width'(bus.i_Config[7:0]);
      cfg_p    = index_width'(bus.i_Config[23:16]);
      free     = ~busy_q;
      // two's-complement trick isolates the lowest set bit = lowest free worker
      pick     = free & (~free + NUM_CU'(1));
      good_res = bus.i_Result_Ready & busy_q;
      bad_res  = bus.i_Result_Ready & ~busy_q;
      ack      = |(bus.i_Indexes_Received & ready_q);
      good_cnt = '0;
      for (int k = 0; k < NUM_CU; k++) good_cnt = good_cnt + CW'(good_res[k]);
   end

   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      row_d       = row_q;
      col_d       = col_q;
      mu_d        = mu_q;
      total_d     = total_q;
      issued_d    = issued_q;
      completed_d = completed_q;
      busy_d      = busy_q;
      ready_d     = ready_q;
      error_d     = error_q | (|bad_res);
      if (state_q != IDLE) begin
         busy_d      = busy_q & ~good_res;
         completed_d = completed_q + good_cnt;
      end
      case (state_q)
         IDLE: if (bus.i_Start) begin
            mu_d        = max_mu_log'(bus.i_Config[15:8]);
            p_d         = cfg_p;
            total_d     = CW'(cfg_n) * CW'(cfg_p);
            row_d       = '0;
            col_d       = '0;
            issued_d    = '0;
            completed_d = '0;
            busy_d      = '0;
            ready_d     = '0;
            state_d     = (cfg_n == '0 || cfg_p == '0) ? FINISH : DISPATCH;
         end
         DISPATCH: if (issued_q < total_q && |free) begin
            ready_d = pick;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: if (ack) begin
            ready_d  = '0;
            busy_d   = busy_d | ready_q;
            issued_d = issued_q + CW'(1);
            if (col_q == p_q - index_width'(1)) begin
               col_d = '0;
               row_d = row_q + index_width'(1);
            end else begin
               col_d = col_q + index_width'(1);
            end
            state_d = (issued_q + CW'(1) < total_q) ? DISPATCH : DRAIN;
         end
         DRAIN:   if (completed_q == total_q) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q     <= IDLE;
         p_q         <= '0;
         row_q       <= '0;
         col_q       <= '0;
         mu_q        <= '0;
         total_q     <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         busy_q      <= '0;
         ready_q     <= '0;
         error_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         row_q       <= row_d;
         col_q       <= col_d;
         mu_q        <= mu_d;
         total_q     <= total_d;
         issued_q    <= issued_d;
         completed_q <= completed_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         done_q      <= (state_q == FINISH);
      end
   end

   assign busy_o              = (state_q == DISPATCH) || (state_q == WAIT_ACK) || (state_q == DRAIN);
   assign bus.o_Busy          = busy_o;
   assign bus.o_Done          = done_q;
   assign bus.o_Error         = error_q;
   assign bus.o_mu            = mu_q;
   assign bus.o_Row_Index     = row_q;
   assign bus.o_Column_Index  = col_q;
   assign bus.o_Indexes_Ready = ready_q;

`ifdef MAIN_CU_PERF_EN
   logic [31:0] cyc_q;
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset)                          cyc_q <= '0;
      else if (state_q == IDLE && bus.i_Start) cyc_q <= '0;
      else if (busy_o && cyc_q != '1)        cyc_q <= cyc_q + 32'd1;
   end
   assign bus.o_Cycle_Count = cyc_q;
`endif
endmodule

// File: tb/tb_main_control_unit.sv
// Directed bench for main_control_unit: row-major dispatch, empty jobs, reordering, errors, reset.
module tb_main_control_unit;
   localparam int NUM_CU = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   main_control_unit_if #(.NUM_CU(NUM_CU), .index_width(8), .max_mu_log(8)) bus ();
   main_control_unit #(.NUM_CU(NUM_CU), .index_width(8), .max_mu_log(8)) dut (
      .i_Clock (clk),
      .i_Reset (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int fails  = 0;

   int disp_n, done_cnt, res_cnt, res_at_done, onehot_viol, done_at;
   int disp_cu [16];
   int disp_row[16];
   int disp_col[16];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start_job(input int n, input int p, input int mu);
      bus.i_Config = {8'h00, 8'(p), 8'(mu), 8'(n)};
      bus.i_Start  = 1'b1;
      step();
      bus.i_Start  = 1'b0;
      $display("start N=%0d P=%0d mu=%0d", n, p, mu);
   endtask

   task automatic wait_rdy(output logic [NUM_CU-1:0] got);
      got = '0;
      for (int c = 0; c < 10; c++) begin
         if (bus.o_Indexes_Ready != '0) begin
            got = bus.o_Indexes_Ready;
            $display("strobe %b row=%0d col=%0d", got, bus.o_Row_Index, bus.o_Column_Index);
            return;
         end
         step();
      end
   endtask

   task automatic ack(input int k);
      bus.i_Indexes_Received[k] = 1'b1;
      step();
      bus.i_Indexes_Received[k] = 1'b0;
   endtask

   task automatic result(input int k);
      bus.i_Result_Ready[k] = 1'b1;
      step();
      bus.i_Result_Ready[k] = 1'b0;
      $display("result cu=%0d", k);
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (bus.o_Done) begin
            seen = 1'b1;
            return;
         end
         step();
      end
   endtask

   // Worker models: ack one cycle after the strobe, result pulse lat cycles after the ack.
   task automatic run_workers(input int lat, input int budget);
      int timer [NUM_CU];
      bit acking[NUM_CU];
      int since_done;
      logic [NUM_CU-1:0] rdy;
      disp_n = 0; done_cnt = 0; res_cnt = 0; res_at_done = -1; onehot_viol = 0; done_at = -1;
      since_done = 0;
      for (int k = 0; k < NUM_CU; k++) begin timer[k] = 0; acking[k] = 1'b0; end
      for (int c = 1; c <= budget; c++) begin
         rdy = bus.o_Indexes_Ready;
         if ($countones(rdy) > 1) onehot_viol++;
         if (bus.o_Done) begin
            if (done_cnt == 0) begin res_at_done = res_cnt; done_at = c; end
            done_cnt++;
         end
         for (int k = 0; k < NUM_CU; k++) begin
            bus.i_Result_Ready[k] = 1'b0;
            if (rdy[k] && !acking[k]) begin
               if (disp_n < 16) begin
                  disp_cu[disp_n]  = k;
                  disp_row[disp_n] = int'(bus.o_Row_Index);
                  disp_col[disp_n] = int'(bus.o_Column_Index);
               end
               $display("dispatch cu=%0d row=%0d col=%0d", k, bus.o_Row_Index, bus.o_Column_Index);
               disp_n++;
               bus.i_Indexes_Received[k] = 1'b1;
               acking[k] = 1'b1;
            end else if (acking[k] && !rdy[k]) begin
               bus.i_Indexes_Received[k] = 1'b0;
               acking[k] = 1'b0;
               timer[k]  = lat;
            end else if (timer[k] > 0) begin
               timer[k]--;
               if (timer[k] == 0) begin
                  bus.i_Result_Ready[k] = 1'b1;
                  res_cnt++;
               end
            end
         end
         if (done_cnt > 0) since_done++;
         if (since_done > 5) break;
         step();
      end
      bus.i_Result_Ready     = '0;
      bus.i_Indexes_Received = '0;
   endtask

   task automatic test_reset();
      step();
      #1;
      checks++; if (bus.o_Indexes_Ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", bus.o_Indexes_Ready); end
      checks++; if (bus.o_Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.o_Busy); end
      checks++; if (bus.o_Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.o_Done); end
      checks++; if (bus.o_Error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", bus.o_Error); end
      checks++; if ({bus.o_mu, bus.o_Row_Index, bus.o_Column_Index} !== 24'h0) begin fails++; $display("FAIL reset_bus: got %h expected 000000", {bus.o_mu, bus.o_Row_Index, bus.o_Column_Index}); end
      step();
      rst_n = 1'b1;
      step(); step();
      checks++; if (bus.o_Busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", bus.o_Busy); end
   endtask

   task automatic test_basic();
      int exp_cu[4]  = '{0, 1, 0, 1};
      int exp_row[4] = '{0, 0, 1, 1};
      int exp_col[4] = '{0, 1, 0, 1};
      start_job(2, 2, 3);
      checks++; if (bus.o_Busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", bus.o_Busy); end
      checks++; if (bus.o_mu !== 8'd3) begin fails++; $display("FAIL basic_mu: got %0d expected 3", bus.o_mu); end
      run_workers(20, 200);
      checks++; if (disp_n !== 4) begin fails++; $display("FAIL basic_count: got %0d expected 4", disp_n); end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (disp_cu[d] !== exp_cu[d] || disp_row[d] !== exp_row[d] || disp_col[d] !== exp_col[d]) begin
            fails++;
            $display("FAIL basic_order%0d: got cu%0d (%0d,%0d) expected cu%0d (%0d,%0d)", d,
                     disp_cu[d], disp_row[d], disp_col[d], exp_cu[d], exp_row[d], exp_col[d]);
         end
      end
      checks++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
      checks++; if (res_at_done !== 4) begin fails++; $display("FAIL basic_done_after: got %0d results expected 4", res_at_done); end
      checks++; if (onehot_viol !== 0) begin fails++; $display("FAIL basic_onehot: got %0d violations expected 0", onehot_viol); end
      checks++; if (bus.o_Error !== 1'b0) begin fails++; $display("FAIL basic_error: got %b expected 0", bus.o_Error); end
   endtask

   task automatic test_empty();
      logic [2:0] seen_done;
      logic       seen_rdy_busy;
      start_job(0, 5, 2);
      seen_done[0] = bus.o_Done;
      seen_rdy_busy = (|bus.o_Indexes_Ready) | bus.o_Busy;
      step();
      seen_done[1] = bus.o_Done;
      seen_rdy_busy |= (|bus.o_Indexes_Ready) | bus.o_Busy;
      step();
      seen_done[2] = bus.o_Done;
      seen_rdy_busy |= (|bus.o_Indexes_Ready) | bus.o_Busy;
      $display("empty job done trace %b", seen_done);
      checks++; if (seen_done !== 3'b010) begin fails++; $display("FAIL empty_done: got %b expected 010", seen_done); end
      checks++; if (seen_rdy_busy !== 1'b0) begin fails++; $display("FAIL empty_dispatch: got %b expected 0", seen_rdy_busy); end
   endtask

   task automatic test_reorder();
      logic [NUM_CU-1:0] got;
      logic              stray;
      bit                seen;
      start_job(1, 3, 1);
      wait_rdy(got);
      checks++; if (got !== 2'b01) begin fails++; $display("FAIL reorder_first: got %b expected 01", got); end
      ack(0);
      wait_rdy(got);
      checks++; if (got !== 2'b10) begin fails++; $display("FAIL reorder_second: got %b expected 10", got); end
      ack(1);
      stray = 1'b0;
      for (int c = 0; c < 3; c++) begin stray |= |bus.o_Indexes_Ready; step(); end
      checks++; if (stray !== 1'b0) begin fails++; $display("FAIL reorder_full: got %b expected 0", stray); end
      result(1);
      wait_rdy(got);
      checks++; if (got !== 2'b10) begin fails++; $display("FAIL reorder_cu1: got %b expected 10", got); end
      checks++; if ({bus.o_Row_Index, bus.o_Column_Index} !== 16'h0002) begin fails++; $display("FAIL reorder_idx: got %h expected 0002", {bus.o_Row_Index, bus.o_Column_Index}); end
      ack(1);
      result(0);
      result(1);
      wait_done(seen);
      checks++; if (seen !== 1'b1) begin fails++; $display("FAIL reorder_done: got %b expected 1", seen); end
   endtask

   task automatic test_back_to_back();
      logic [NUM_CU-1:0] got;
      bit                seen;
      start_job(1, 2, 1);
      wait_rdy(got);
      ack(0);
      wait_rdy(got);
      checks++; if (got !== 2'b10) begin fails++; $display("FAIL b2b_strobe: got %b expected 10", got); end
      bus.i_Indexes_Received[1] = 1'b1;
      bus.i_Result_Ready[0]     = 1'b1;
      step();
      bus.i_Indexes_Received[1] = 1'b0;
      bus.i_Result_Ready[0]     = 1'b0;
      $display("ack cu=1 with result cu=0");
      step(); step();
      checks++; if ({bus.o_Busy, bus.o_Done} !== 2'b10) begin fails++; $display("FAIL b2b_draining: got %b expected 10", {bus.o_Busy, bus.o_Done}); end
      result(1);
      wait_done(seen);
      checks++; if (seen !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b expected 1", seen); end
      checks++; if (bus.o_Error !== 1'b0) begin fails++; $display("FAIL b2b_error: got %b expected 0", bus.o_Error); end
   endtask

   task automatic test_error();
      logic [NUM_CU-1:0] got;
      logic              early;
      bit                seen;
      start_job(1, 1, 1);
      wait_rdy(got);
      ack(0);
      checks++; if (bus.o_Error !== 1'b0) begin fails++; $display("FAIL err_before: got %b expected 0", bus.o_Error); end
      result(1);
      checks++; if (bus.o_Error !== 1'b1) begin fails++; $display("FAIL err_set: got %b expected 1", bus.o_Error); end
      early = 1'b0;
      for (int c = 0; c < 4; c++) begin early |= bus.o_Done; step(); end
      checks++; if (early !== 1'b0) begin fails++; $display("FAIL err_uncounted: got %b expected 0", early); end
      result(0);
      wait_done(seen);
      checks++; if (seen !== 1'b1) begin fails++; $display("FAIL err_done: got %b expected 1", seen); end
      checks++; if (bus.o_Error !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", bus.o_Error); end
   endtask

   task automatic test_reset_mid();
      logic [NUM_CU-1:0] got;
      start_job(3, 3, 4);
      wait_rdy(got);
      ack(0);
      wait_rdy(got);
      ack(1);
      step();
      rst_n = 1'b0;
      #1;
      $display("reset asserted mid-job");
      checks++; if ({bus.o_Busy, bus.o_Done, bus.o_Error, bus.o_Indexes_Ready} !== 5'b0) begin fails++; $display("FAIL mid_status: got %b expected 00000", {bus.o_Busy, bus.o_Done, bus.o_Error, bus.o_Indexes_Ready}); end
      checks++; if ({bus.o_mu, bus.o_Row_Index, bus.o_Column_Index} !== 24'h0) begin fails++; $display("FAIL mid_bus: got %h expected 000000", {bus.o_mu, bus.o_Row_Index, bus.o_Column_Index}); end
      step();
      rst_n = 1'b1;
      step();
      start_job(1, 1, 6);
      run_workers(5, 60);
      checks++; if (disp_n !== 1 || disp_cu[0] !== 0 || disp_row[0] !== 0 || disp_col[0] !== 0) begin fails++; $display("FAIL mid_dispatch: got n=%0d cu%0d (%0d,%0d) expected n=1 cu0 (0,0)", disp_n, disp_cu[0], disp_row[0], disp_col[0]); end
      checks++; if (done_cnt !== 1 || res_at_done !== 1) begin fails++; $display("FAIL mid_done: got %0d/%0d expected 1/1", done_cnt, res_at_done); end
      checks++; if (done_at !== 11) begin fails++; $display("FAIL mid_latency: got %0d expected 11", done_at); end
      checks++; if (bus.o_Error !== 1'b0) begin fails++; $display("FAIL mid_error: got %b expected 0", bus.o_Error); end
`ifdef MAIN_CU_PERF_EN
      checks++; if (bus.o_Cycle_Count !== 32'd9) begin fails++; $display("FAIL mid_cycles: got %0d expected 9", bus.o_Cycle_Count); end
`endif
   endtask

   initial begin
      bus.i_Start            = 1'b0;
      bus.i_Config           = '0;
      bus.i_Indexes_Received = '0;
      bus.i_Result_Ready     = '0;
      test_reset();
      test_basic();
      test_empty();
      test_reorder();
      test_back_to_back();
      test_error();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
